sfx_sequencer: RTL
==================

Name: sfx_sequencer

Overview:
- Consumes the one-cycle sound-trigger pulses `eat_sound`, `hit_sound` and `die_sound` from the APU trigger stage.
- For each trigger it plays a short fixed sound effect: a 4-step note sequence with frame-timed steps.
- Outputs a 1-bit square-wave audio stream to the board audio pin / PWM output.
- Sits directly downstream of the trigger stage, in the same clock domain as the VGA/game logic.

Parameters:
- PERIOD_SHIFT, 6: tone half-period in clocks = note_code << PERIOD_SHIFT.
- STEP_FRAMES, 4: number of `frame_end` pulses per note step (range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- frame_end  input  1  one-cycle pulse once per video frame; step timebase.
- eat_sound  input  1  one-cycle trigger for the eat effect.
- hit_sound  input  1  one-cycle trigger for the hit effect.
- die_sound  input  1  one-cycle trigger for the die effect.
- mute  input  1  forces `audio_out` low; sequencing continues unchanged.
- audio_out  output  1  square-wave audio.
- busy  output  1  high while an effect is playing.
- active_sfx  output  2  effect being played: 0 none, 1 eat, 2 hit, 3 die.

Behaviour:
- Reset (reset=0, async): state IDLE, `audio_out`=0, `busy`=0, `active_sfx`=0, all counters 0.
- Note ROM: four 8-bit codes per effect, step 0 first; code 0x00 = rest.
  - eat: 0x40, 0x30, 0x20, 0x18.
  - hit: 0x80, 0x00, 0x80, 0x00.
  - die: 0x20, 0x30, 0x40, 0x60.
- Priority: die(3) > hit(2) > eat(1).
  - Simultaneous triggers in one cycle: the highest-priority trigger wins; the others are dropped.
- States: IDLE and PLAY.
  - IDLE -> PLAY on any trigger at a clk edge.
  - PLAY -> PLAY (restart) on a trigger whose priority >= `active_sfx`. Lower-priority triggers are ignored.
  - PLAY -> IDLE after the last frame of step 3.
- Start or restart takes effect on the clk edge that samples the trigger:
  - `active_sfx` = new id, step=0, frame_cnt=0, square=0.
  - tone_cnt = half_period-1, where half_period = code << PERIOD_SHIFT, computed 16 bits wide.
  - `busy`=1 from that edge; latency 1 cycle from trigger to outputs.
- Tone generator (PLAY, non-rest code):
  - tone_cnt decrements each clk.
  - At tone_cnt=0: toggle square and reload half_period-1.
  - Period is 2*half_period clocks.
- Rest code: square held 0 and tone_cnt held.
- Step timing (PLAY): on each `frame_end`, frame_cnt increments.
  - When frame_cnt reaches STEP_FRAMES-1 and `frame_end`=1: frame_cnt=0 and step advances.
  - On step advance, square=0 and tone_cnt reloads from the new code.
  - If step was 3: go to IDLE, `busy`=0, `active_sfx`=0, square=0.
- `frame_end` coincident with a trigger: the trigger wins and the frame pulse is not counted toward the new effect.
- `frame_end` in IDLE: no effect.
- `audio_out` = square & ~mute & busy, registered; it is 0 in IDLE.
- Asserting reset mid-effect: everything returns to reset values immediately; no residual tone after release.
- Effect length = 4*STEP_FRAMES frames, independent of clk frequency.

Test Plan:
- PERIOD_SHIFT=2, STEP_FRAMES=2; reset released, eat_sound pulse -> next cycle busy=1, active_sfx=1; audio_out toggles every 256 clks during step 0.
- Same config; apply 2 frame_end pulses per step -> half-periods of 256, 192, 128, 96 clks; after the 8th frame_end, busy=0, active_sfx=0, audio_out=0.
- hit_sound -> step 0 toggles every 512 clks; steps 1 and 3 audio_out stays 0 for the whole step.
- eat and die pulsed in the same cycle -> active_sfx=3; eat_sound during die play -> ignored, active_sfx stays 3.
- die_sound during an eat effect at step 2 -> restart: active_sfx=3, step 0, first toggle after 128 clks.
- mute=1 during die -> audio_out=0 but busy timing unchanged; reset pulsed low mid-effect -> busy, active_sfx and audio_out all 0 asynchronously.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays a fixed 4-step square-wave note sequence for
// each eat/hit/die trigger. Each step lasts STEP_FRAMES frame_end pulses.
// Output is a 1-bit square wave suitable for a PWM/audio pin.
module sfx_sequencer #(
    parameter int PERIOD_SHIFT = 6,
    parameter int STEP_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       eat_sound,
    input  logic       hit_sound,
    input  logic       die_sound,
    input  logic       mute,
    output logic       audio_out,
    output logic       busy,
    output logic [1:0] active_sfx
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sfx_q, sfx_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic        square_q, square_d;
    logic        audio_q, audio_d;

    logic [1:0]  trig_id;
    logic        start;
    logic        last_frame;
    logic [7:0]  cur_code;
    logic [7:0]  next_code;
    logic [7:0]  start_code;

    // Note table: four codes per effect, step 0 first; 0x00 means rest.
    function automatic logic [7:0] note_code(input logic [1:0] sfx, input logic [1:0] step);
        logic [7:0] code;
        case ({sfx, step})
            4'b01_00: code = 8'h40;
            4'b01_01: code = 8'h30;
            4'b01_10: code = 8'h20;
            4'b01_11: code = 8'h18;
            4'b10_00: code = 8'h80;
            4'b10_01: code = 8'h00;
            4'b10_10: code = 8'h80;
            4'b10_11: code = 8'h00;
            4'b11_00: code = 8'h20;
            4'b11_01: code = 8'h30;
            4'b11_10: code = 8'h40;
            4'b11_11: code = 8'h60;
            default:  code = 8'h00;
        endcase
        return code;
    endfunction

    // Reload value for the tone counter: half-period minus one, 16 bits wide.
    function automatic logic [15:0] reload_of(input logic [7:0] code);
        logic [15:0] half_period;
        half_period = {8'h00, code} << PERIOD_SHIFT;
        return half_period - 16'd1;
    endfunction

    // Priority-encode simultaneous triggers; die beats hit beats eat.
    always_comb begin
        trig_id = 2'd0;
        if (die_sound)      trig_id = 2'd3;
        else if (hit_sound) trig_id = 2'd2;
        else if (eat_sound) trig_id = 2'd1;
    end

    // In IDLE sfx_q is 0, so any trigger starts; in PLAY only equal/higher priority restarts.
    assign start      = (trig_id != 2'd0) && (trig_id >= sfx_q);
    assign last_frame = frame_end && (frame_cnt_q == 4'(STEP_FRAMES - 1));
    assign cur_code   = note_code(sfx_q, step_q);
    assign next_code  = note_code(sfx_q, step_q + 2'd1);
    assign start_code = note_code(trig_id, 2'd0);

    // Next-state logic: start/restart, step timing, and the tone generator.
    always_comb begin
        state_d     = state_q;
        sfx_d       = sfx_q;
        step_d      = step_q;
        frame_cnt_d = frame_cnt_q;
        tone_cnt_d  = tone_cnt_q;
        square_d    = square_q;

        if (start) begin
            // A trigger swallows any coincident frame pulse.
            state_d     = PLAY;
            sfx_d       = trig_id;
            step_d      = 2'd0;
            frame_cnt_d = 4'd0;
            square_d    = 1'b0;
            tone_cnt_d  = reload_of(start_code);
        end else if (state_q == PLAY) begin
            if (last_frame) begin
                frame_cnt_d = 4'd0;
                square_d    = 1'b0;
                if (step_q == 2'd3) begin
                    state_d    = IDLE;
                    sfx_d      = 2'd0;
                    step_d     = 2'd0;
                    tone_cnt_d = 16'd0;
                end else begin
                    step_d     = step_q + 2'd1;
                    tone_cnt_d = reload_of(next_code);
                end
            end else begin
                if (frame_end) begin
                    frame_cnt_d = frame_cnt_q + 4'd1;
                end
                if (cur_code == 8'h00) begin
                    // Rest: silence, counter frozen.
                    square_d = 1'b0;
                end else if (tone_cnt_q == 16'd0) begin
                    square_d   = ~square_q;
                    tone_cnt_d = reload_of(cur_code);
                end else begin
                    tone_cnt_d = tone_cnt_q - 16'd1;
                end
            end
        end
    end

    // Output register tracks the next square value so audio lines up with busy.
    assign audio_d = square_d & ~mute & (state_d == PLAY);

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sfx_q       <= 2'd0;
            step_q      <= 2'd0;
            frame_cnt_q <= 4'd0;
            tone_cnt_q  <= 16'd0;
            square_q    <= 1'b0;
            audio_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sfx_q       <= sfx_d;
            step_q      <= step_d;
            frame_cnt_q <= frame_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            square_q    <= square_d;
            audio_q     <= audio_d;
        end
    end

    assign audio_out  = audio_q;
    assign busy       = (state_q == PLAY);
    assign active_sfx = sfx_q;

endmodule
